dual_issue_ctrl: RTL and testbench

Issue scheduler between DECODE and execute in the 2-wide pipeline. It accepts one decoded instruction pair per cycle and checks the pair for intra-pair hazards. Hazard-free pairs issue together. Hazardous pairs are split across two cycles in program order. Upstream and downstream are decoupled with a valid/ready handshake, and a registered output stage gives a fixed 1-cycle latency.

---
 rtl/dual_issue_ctrl_pkg.sv | 44 ++++
 rtl/dual_issue_ctrl_pair_hazard_check.sv | 34 +++
 rtl/dual_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_dual_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and helpers for the dual-issue scheduler between decode and execute.
package dual_issue_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int IMM_W   = 12;
    localparam int ALUOP_W = 2;

    // One decoded instruction as produced by the decode stage.
    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;    // 1: second ALU operand is the immediate
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_W-1:0]   dst;
        logic [REG_W-1:0]   src0;
        logic [REG_W-1:0]   src1;
        logic [IMM_W-1:0]   imm;
    } decode_struct;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SPLIT = 2'd2
    } issue_state_e;

    localparam decode_struct DECODE_NOP = '0;

    // A slot that writes nothing, touches no memory and has no ALU work is a bubble.
    function automatic logic is_nop(input decode_struct d);
        return !d.reg_write && !d.mem_read && !d.mem_write && (d.alu_op == '0);
    endfunction

    // The second source register is only read for register-register ops and stores.
    function automatic logic uses_src1(input decode_struct d);
        return !d.alu_src || d.mem_write;
    endfunction

    // Any slot that needs the single data-memory port.
    function automatic logic uses_mem(input decode_struct d);
        return d.mem_read || d.mem_write;
    endfunction

endpackage

// File: rtl/dual_issue_ctrl_pair_hazard_check.sv
// Combinational intra-pair hazard detection; slot0 is the older instruction.
module pair_hazard_check
    import dual_issue_ctrl_pkg::*;
(
    input  decode_struct slot0,
    input  decode_struct slot1,
    output logic         raw,
    output logic         waw,
    output logic         mem,
    output logic         hazard
);

    logic both_live;
    logic dst0_live;
    logic unused_fields;

    // Bubbles never conflict with anything, so every cause is gated by both slots being real.
    assign both_live = !is_nop(slot0) && !is_nop(slot1);
    assign dst0_live = slot0.reg_write && (slot0.dst != '0);

    assign raw = both_live && dst0_live &&
                 ((slot0.dst == slot1.src0) ||
                  (uses_src1(slot1) && (slot0.dst == slot1.src1)));

    assign waw = both_live && dst0_live && slot1.reg_write && (slot0.dst == slot1.dst);

    assign mem = both_live && uses_mem(slot0) && uses_mem(slot1);

    assign hazard = raw || waw || mem;

    // Operand and immediate fields that play no part in pair ordering.
    assign unused_fields = ^{slot0.alu_src, slot0.src0, slot0.src1, slot0.imm, slot1.imm};

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue scheduler: accepts a decoded pair, issues it whole or split in
// program order, behind a single registered output stage.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  decode_struct       i_decode_data [0:1],
    output logic               o_valid,
    input  logic               i_ready,
    output decode_struct       o_issue_data [0:1],
    output logic [1:0]         o_slot_valid,
    output logic [CNT_W-1:0]   o_split_count
);

    // Split events are a performance statistic; the counter parks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    issue_state_e     state_p1, state_nxt;
    decode_struct     issue_p1 [0:1];
    decode_struct     issue_nxt [0:1];
    decode_struct     hold_p1, hold_nxt;
    logic [1:0]       slot_vld_p1, slot_vld_nxt;
    logic [CNT_W-1:0] split_cnt_p1, split_cnt_nxt;

    logic             accept;
    logic             nop0, nop1;
    logic             hz_raw, hz_waw, hz_mem, hz_any;
    logic             unused_causes;

    pair_hazard_check u_hazard (
        .slot0  (i_decode_data[0]),
        .slot1  (i_decode_data[1]),
        .raw    (hz_raw),
        .waw    (hz_waw),
        .mem    (hz_mem),
        .hazard (hz_any)
    );

    // Individual causes are kept visible for debug; only the combined flag steers issue.
    assign unused_causes = hz_raw ^ hz_waw ^ hz_mem;

    assign nop0 = is_nop(i_decode_data[0]);
    assign nop1 = is_nop(i_decode_data[1]);

    // A new pair fits only when the output stage is free or drains this cycle;
    // a parked slot1 must leave before anything new enters.
    assign o_ready = !i_rst && !i_flush &&
                     ((state_p1 == EMPTY) || ((state_p1 == FULL) && i_ready));
    assign accept  = i_valid && o_ready;

    // Next-state and next-output selection for the issue stage.
    always_comb begin
        state_nxt     = state_p1;
        issue_nxt[0]  = issue_p1[0];
        issue_nxt[1]  = issue_p1[1];
        hold_nxt      = hold_p1;
        slot_vld_nxt  = slot_vld_p1;
        split_cnt_nxt = split_cnt_p1;

        if (accept) begin
            if (hz_any) begin
                issue_nxt[0]  = i_decode_data[0];
                issue_nxt[1]  = DECODE_NOP;
                slot_vld_nxt  = 2'b01;
                hold_nxt      = i_decode_data[1];
                split_cnt_nxt = sat_inc(split_cnt_p1);
                state_nxt     = SPLIT;
            end else begin
                issue_nxt[0]  = i_decode_data[0];
                issue_nxt[1]  = i_decode_data[1];
                slot_vld_nxt  = {!nop1, !nop0};
                // An all-bubble pair leaves nothing to issue.
                state_nxt     = (nop0 && nop1) ? EMPTY : FULL;
            end
        end else begin
            case (state_p1)
                SPLIT: begin
                    if (i_ready) begin
                        issue_nxt[0] = DECODE_NOP;
                        issue_nxt[1] = hold_p1;
                        slot_vld_nxt = 2'b10;
                        state_nxt    = FULL;
                    end
                end
                FULL: begin
                    if (i_ready) begin
                        slot_vld_nxt = 2'b00;
                        state_nxt    = EMPTY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---- stage p1: output and hold registers ----
    // Reset clears everything; flush clears everything except the statistic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_p1     <= EMPTY;
            issue_p1[0]  <= DECODE_NOP;
            issue_p1[1]  <= DECODE_NOP;
            hold_p1      <= DECODE_NOP;
            slot_vld_p1  <= 2'b00;
            split_cnt_p1 <= '0;
        end else if (i_flush) begin
            state_p1     <= EMPTY;
            issue_p1[0]  <= DECODE_NOP;
            issue_p1[1]  <= DECODE_NOP;
            hold_p1      <= DECODE_NOP;
            slot_vld_p1  <= 2'b00;
        end else begin
            state_p1     <= state_nxt;
            issue_p1[0]  <= issue_nxt[0];
            issue_p1[1]  <= issue_nxt[1];
            hold_p1      <= hold_nxt;
            slot_vld_p1  <= slot_vld_nxt;
            split_cnt_p1 <= split_cnt_nxt;
        end
    end

    assign o_valid         = (state_p1 != EMPTY);
    assign o_issue_data[0] = issue_p1[0];
    assign o_issue_data[1] = issue_p1[1];
    assign o_slot_valid    = slot_vld_p1;
    assign o_split_count   = split_cnt_p1;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed pairs with literal expectations, then
// randomized traffic checked every cycle against an issue-queue model.
module tb_dual_issue_ctrl;
    import dual_issue_ctrl_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_flush = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    decode_struct     i_decode_data [0:1];
    logic             o_valid;
    logic             i_ready = 1'b0;
    decode_struct     o_issue_data [0:1];
    logic [1:0]       o_slot_valid;
    logic [CNT_W-1:0] o_split_count;

    dual_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_decode_data (i_decode_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_issue_data  (o_issue_data),
        .o_slot_valid  (o_slot_valid),
        .o_split_count (o_split_count)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    logic last_ready;

    // Model: the group on the output, an optional second half still owed, and the split tally.
    bit           m_cur_v  = 1'b0;
    decode_struct m_cur [0:1];
    logic [1:0]   m_sv     = 2'b00;
    bit           m_pend_v = 1'b0;
    decode_struct m_pend;
    int           m_splits = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic decode_struct mk(input bit rw, input bit mr, input bit mw, input bit as,
                                        input int op, input int dst, input int s0, input int s1,
                                        input int imm);
        decode_struct d;
        d.reg_write = rw;
        d.mem_read  = mr;
        d.mem_write = mw;
        d.alu_src   = as;
        d.alu_op    = 2'(op);
        d.dst       = 5'(dst);
        d.src0      = 5'(s0);
        d.src1      = 5'(s1);
        d.imm       = 12'(imm);
        return d;
    endfunction

    function automatic bit m_bubble(input decode_struct d);
        return !(d.reg_write || d.mem_read || d.mem_write) && (d.alu_op == 0);
    endfunction

    // Program-order conflict between the older instruction a and the younger b.
    function automatic bit m_conflict(input decode_struct a, input decode_struct b);
        bit b_reads_rs2;
        if (m_bubble(a) || m_bubble(b)) return 1'b0;
        b_reads_rs2 = (b.alu_src == 1'b0) || b.mem_write;
        if (a.reg_write && a.dst != 0 &&
            (a.dst == b.src0 || (b_reads_rs2 && a.dst == b.src1))) return 1'b1;
        if (a.reg_write && b.reg_write && a.dst != 0 && a.dst == b.dst) return 1'b1;
        if ((a.mem_read || a.mem_write) && (b.mem_read || b.mem_write)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return !i_rst && !i_flush && (!m_cur_v || (!m_pend_v && i_ready));
    endfunction

    task automatic model_step();
        bit acc;
        acc = i_valid && m_ready();
        if (i_rst || i_flush) begin
            m_cur_v  = 1'b0;
            m_cur[0] = DECODE_NOP;
            m_cur[1] = DECODE_NOP;
            m_sv     = 2'b00;
            m_pend_v = 1'b0;
            if (i_rst) m_splits = 0;
        end else if (acc) begin
            if (m_conflict(i_decode_data[0], i_decode_data[1])) begin
                m_cur[0] = i_decode_data[0];
                m_cur[1] = DECODE_NOP;
                m_sv     = 2'b01;
                m_cur_v  = 1'b1;
                m_pend   = i_decode_data[1];
                m_pend_v = 1'b1;
                if (m_splits < CNT_MAX) m_splits++;
            end else begin
                m_cur[0] = i_decode_data[0];
                m_cur[1] = i_decode_data[1];
                m_sv     = {!m_bubble(i_decode_data[1]), !m_bubble(i_decode_data[0])};
                m_cur_v  = (m_sv != 2'b00);
            end
        end else if (m_cur_v && i_ready) begin
            if (m_pend_v) begin
                m_cur[0] = DECODE_NOP;
                m_cur[1] = m_pend;
                m_sv     = 2'b10;
                m_pend_v = 1'b0;
            end else begin
                m_cur_v = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("o_valid", 64'(o_valid), 64'(m_cur_v));
        chk("o_split_count", 64'(o_split_count), 64'(m_splits));
        if (m_cur_v) begin
            chk("o_slot_valid", 64'(o_slot_valid), 64'(m_sv));
            chk("o_issue_data0", 64'(o_issue_data[0]), 64'(m_cur[0]));
            chk("o_issue_data1", 64'(o_issue_data[1]), 64'(m_cur[1]));
        end
    endtask

    // One clock: drive at the falling edge, check o_ready, advance the model at the
    // rising edge, check the registered outputs at the next falling edge.
    task automatic cycle(input bit v, input decode_struct d0, input decode_struct d1,
                         input bit rdy, input bit fl, input bit rs);
        i_valid          = v;
        i_decode_data[0] = d0;
        i_decode_data[1] = d1;
        i_ready          = rdy;
        i_flush          = fl;
        i_rst            = rs;
        #1;
        last_ready = o_ready;
        chk("o_ready", 64'(o_ready), 64'(m_ready()));
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check_outputs();
    endtask

    function automatic decode_struct rnd_instr();
        int r0, r1, r2;
        r0 = int'($urandom_range(0, 4));
        r1 = int'($urandom_range(0, 4));
        r2 = int'($urandom_range(0, 4));
        case ($urandom_range(0, 5))
            0:       return DECODE_NOP;
            1:       return mk(1, 0, 0, 0, 2, r0, r1, r2, 0);
            2:       return mk(1, 0, 0, 1, 3, r0, r1, r2, int'($urandom_range(0, 4095)));
            3:       return mk(1, 1, 0, 1, 0, r0, r1, r2, int'($urandom_range(0, 64)));
            4:       return mk(0, 0, 1, 1, 0, r0, r1, r2, int'($urandom_range(0, 64)));
            default: return mk(0, 0, 0, 0, 1, r0, r1, r2, 8);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        decode_struct add_i, addi_i, sub_i, lw_i, sw_i, addi_x7, addi_x10, nop_i;
        add_i    = mk(1, 0, 0, 0, 2, 3, 1, 2, 0);
        addi_i   = mk(1, 0, 0, 1, 3, 6, 4, 0, 5);
        sub_i    = mk(1, 0, 0, 0, 2, 5, 3, 4, 0);
        lw_i     = mk(1, 1, 0, 1, 0, 7, 1, 0, 0);
        sw_i     = mk(0, 0, 1, 1, 0, 0, 2, 8, 4);
        addi_x7  = mk(1, 0, 0, 1, 3, 9, 7, 7, 1);
        addi_x10 = mk(1, 0, 0, 1, 3, 9, 10, 7, 1);
        nop_i    = DECODE_NOP;
        i_decode_data[0] = nop_i;
        i_decode_data[1] = nop_i;
        m_cur[0] = nop_i;
        m_cur[1] = nop_i;
        m_pend   = nop_i;

        @(negedge i_clk);

        // Reset held two cycles with a pair offered.
        repeat (2) begin
            cycle(1, add_i, addi_i, 1, 0, 1);
            chk("rst_ready", 64'(last_ready), 64'd0);
        end
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_slot_valid", 64'(o_slot_valid), 64'd0);
        chk("rst_count", 64'(o_split_count), 64'd0);
        chk("rst_data0", 64'(o_issue_data[0]), 64'd0);

        // Independent pair, then the same pair back to back with no bubble.
        cycle(1, add_i, addi_i, 1, 0, 0);
        chk("ind_ready", 64'(last_ready), 64'd1);
        chk("ind_valid", 64'(o_valid), 64'd1);
        chk("ind_slot_valid", 64'(o_slot_valid), 64'h3);
        chk("ind_data0", 64'(o_issue_data[0]), 64'(add_i));
        chk("ind_data1", 64'(o_issue_data[1]), 64'(addi_i));
        cycle(1, add_i, addi_i, 1, 0, 0);
        chk("b2b_ready", 64'(last_ready), 64'd1);
        chk("b2b_slot_valid", 64'(o_slot_valid), 64'h3);
        cycle(0, nop_i, nop_i, 1, 0, 0);
        chk("drain_valid", 64'(o_valid), 64'd0);

        // RAW pair splits across two output cycles.
        cycle(1, add_i, sub_i, 1, 0, 0);
        chk("raw_slot_a", 64'(o_slot_valid), 64'h1);
        chk("raw_data0", 64'(o_issue_data[0]), 64'(add_i));
        chk("raw_data1_zero", 64'(o_issue_data[1]), 64'd0);
        chk("raw_count", 64'(o_split_count), 64'd1);
        cycle(0, nop_i, nop_i, 1, 0, 0);
        chk("raw_ready_low", 64'(last_ready), 64'd0);
        chk("raw_slot_b", 64'(o_slot_valid), 64'h2);
        chk("raw_data1", 64'(o_issue_data[1]), 64'(sub_i));
        chk("raw_data0_zero", 64'(o_issue_data[0]), 64'd0);
        cycle(0, nop_i, nop_i, 1, 0, 0);

        // Load/store pair competes for the memory port.
        cycle(1, lw_i, sw_i, 1, 0, 0);
        chk("mem_slot_a", 64'(o_slot_valid), 64'h1);
        chk("mem_count", 64'(o_split_count), 64'd2);
        cycle(0, nop_i, nop_i, 1, 0, 0);
        chk("mem_data1", 64'(o_issue_data[1]), 64'(sw_i));
        cycle(0, nop_i, nop_i, 1, 0, 0);

        // Immediate-form consumer: Src0 match splits, Src1 is ignored.
        cycle(1, lw_i, addi_x7, 1, 0, 0);
        chk("src0_slot", 64'(o_slot_valid), 64'h1);
        chk("src0_count", 64'(o_split_count), 64'd3);
        cycle(0, nop_i, nop_i, 1, 0, 0);
        cycle(0, nop_i, nop_i, 1, 0, 0);
        cycle(1, lw_i, addi_x10, 1, 0, 0);
        chk("src1_ignored_slot", 64'(o_slot_valid), 64'h3);
        chk("src1_ignored_count", 64'(o_split_count), 64'd3);
        cycle(0, nop_i, nop_i, 1, 0, 0);

        // Backpressure in the split state.
        cycle(1, add_i, sub_i, 1, 0, 0);
        chk("bp_count", 64'(o_split_count), 64'd4);
        repeat (3) begin
            cycle(1, add_i, addi_i, 0, 0, 0);
            chk("bp_ready", 64'(last_ready), 64'd0);
            chk("bp_slot", 64'(o_slot_valid), 64'h1);
            chk("bp_data0", 64'(o_issue_data[0]), 64'(add_i));
        end
        cycle(0, nop_i, nop_i, 1, 0, 0);
        chk("bp_release_slot", 64'(o_slot_valid), 64'h2);
        chk("bp_release_data1", 64'(o_issue_data[1]), 64'(sub_i));
        cycle(0, nop_i, nop_i, 1, 0, 0);

        // Flush while split keeps the count and drops the parked slot.
        cycle(1, add_i, sub_i, 1, 0, 0);
        chk("fl_count_before", 64'(o_split_count), 64'd5);
        cycle(1, add_i, addi_i, 0, 1, 0);
        chk("fl_ready", 64'(last_ready), 64'd0);
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_count", 64'(o_split_count), 64'd5);
        chk("fl_slot", 64'(o_slot_valid), 64'd0);
        cycle(0, nop_i, nop_i, 1, 0, 0);
        chk("fl_after_valid", 64'(o_valid), 64'd0);

        // An all-bubble pair is taken but produces no group.
        cycle(1, nop_i, nop_i, 1, 0, 0);
        chk("nop_ready", 64'(last_ready), 64'd1);
        chk("nop_valid", 64'(o_valid), 64'd0);
        chk("nop_slot", 64'(o_slot_valid), 64'd0);

        // Randomized traffic; the narrow counter saturates along the way.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 4) != 0), rnd_instr(), rnd_instr(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 399) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
